// File: rtl/matrix_add_result_serializer_pkg.sv
// Shared parameters, width helpers and FSM encoding for the MatrixAdd result serializer.
package matrix_add_result_serializer_pkg;

    localparam int IN_WIDTH_DEF = 16;
    localparam int ROWS_DEF     = 10;
    localparam int COLS_DEF     = 12;

    // Sum of two IN_WIDTH operands needs one extra bit.
    function automatic int elem_width(input int in_width);
        return in_width + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/matrix_add_result_serializer_sum_bank.sv
// One matrix buffer: loads the whole flat sum vector in a single cycle, reads one element by (row, col).
module matrix_sum_bank
    import matrix_add_result_serializer_pkg::*;
#(
    parameter int IN_WIDTH = IN_WIDTH_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_load,
    input  logic [ROWS*COLS*elem_width(IN_WIDTH)-1:0] i_flat,
    input  logic                                  i_set_no,
    input  logic [idx_width(ROWS)-1:0]            i_row,
    input  logic [idx_width(COLS)-1:0]            i_col,
    output logic [elem_width(IN_WIDTH)-1:0]       o_elem,
    output logic                                  o_set_no
);
    localparam int W = elem_width(IN_WIDTH);

    logic [ROWS*COLS*W-1:0] r_mem;
    logic                   r_set_no;
    int                     w_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem    <= '0;
            r_set_no <= 1'b0;
        end else if (i_load) begin
            r_mem    <= i_flat;
            r_set_no <= i_set_no;
        end
    end

    assign w_idx    = int'(i_row) * COLS + int'(i_col);
    assign o_elem   = r_mem[w_idx*W +: W];
    assign o_set_no = r_set_no;

endmodule

// File: rtl/matrix_add_result_serializer.sv
// Captures a full MatrixAdd sum matrix into one of two banks and streams it element by element
// (column-fastest) over a valid/ready link.
module matrix_add_result_serializer
    import matrix_add_result_serializer_pkg::*;
#(
    parameter int IN_WIDTH = IN_WIDTH_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_enable,
    input  logic                                      i_sum_ready,
    input  logic                                      i_sum_set_no,
    input  logic [ROWS*COLS*elem_width(IN_WIDTH)-1:0] i_sum_flat,
    output logic                                      o_can_accept,
    output logic                                      o_out_valid,
    input  logic                                      i_out_ready,
    output logic [elem_width(IN_WIDTH)-1:0]           o_out_data,
    output logic [idx_width(ROWS)-1:0]                o_out_row,
    output logic [idx_width(COLS)-1:0]                o_out_col,
    output logic                                      o_out_set_no,
    output logic                                      o_out_last,
    output logic                                      o_overflow
);
    localparam int W  = elem_width(IN_WIDTH);
    localparam int RW = idx_width(ROWS);
    localparam int CW = idx_width(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    state_e        r_state, w_state_nxt;
    logic [1:0]    r_full;
    logic          r_wr_ptr, r_rd_ptr;
    logic          r_valid, r_last, r_set_no, r_overflow;
    logic [W-1:0]  r_data;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [CW-1:0] r_col, w_col_nxt;

    logic          w_valid_nxt, w_load_out, w_rd_sel, w_free, w_cap, w_drop;
    logic [W-1:0]  w_elem [2];
    logic [1:0]    w_bank_set;

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_valid_nxt = r_valid;
        w_load_out  = 1'b0;
        w_rd_sel    = r_rd_ptr;
        w_free      = 1'b0;
        if (i_enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_rd_ptr]) begin
                        w_state_nxt = ST_STREAM;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_valid_nxt = 1'b1;
                        w_load_out  = 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (i_out_ready) begin
                        if (r_row == LAST_ROW && r_col == LAST_COL) begin
                            w_free   = 1'b1;
                            w_rd_sel = ~r_rd_ptr;
                            // Other bank already waiting: continue straight into it, no bubble.
                            if (r_full[~r_rd_ptr]) begin
                                w_row_nxt  = '0;
                                w_col_nxt  = '0;
                                w_load_out = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_valid_nxt = 1'b0;
                            end
                        end else if (r_col == LAST_COL) begin
                            w_row_nxt  = r_row + RW'(1);
                            w_col_nxt  = '0;
                            w_load_out = 1'b1;
                        end else begin
                            w_col_nxt  = r_col + CW'(1);
                            w_load_out = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // A bank being freed by the final handshake may be refilled on the same edge.
    assign w_cap  = i_enable & i_sum_ready &
                    (~r_full[r_wr_ptr] | (w_free & (r_wr_ptr == r_rd_ptr)));
    assign w_drop = i_enable & i_sum_ready & ~w_cap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_full     <= 2'b00;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_set_no   <= 1'b0;
            r_overflow <= 1'b0;
            r_data     <= '0;
            r_row      <= '0;
            r_col      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            for (int i = 0; i < 2; i++) begin
                r_full[i] <= (r_full[i] & ~(w_free & (r_rd_ptr == 1'(i))))
                           | (w_cap & (r_wr_ptr == 1'(i)));
            end
            if (w_cap)  r_wr_ptr   <= ~r_wr_ptr;
            if (w_free) r_rd_ptr   <= ~r_rd_ptr;
            if (w_drop) r_overflow <= 1'b1;
            if (w_load_out) begin
                r_data   <= w_elem[w_rd_sel];
                r_set_no <= w_bank_set[w_rd_sel];
                r_last   <= (w_row_nxt == LAST_ROW) && (w_col_nxt == LAST_COL);
            end else if (!w_valid_nxt) begin
                r_last   <= 1'b0;
            end
        end
    end

    matrix_sum_bank #(.IN_WIDTH(IN_WIDTH), .ROWS(ROWS), .COLS(COLS)) u_bank0 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_cap & (r_wr_ptr == 1'b0)),
        .i_flat   (i_sum_flat),
        .i_set_no (i_sum_set_no),
        .i_row    (w_row_nxt),
        .i_col    (w_col_nxt),
        .o_elem   (w_elem[0]),
        .o_set_no (w_bank_set[0])
    );

    matrix_sum_bank #(.IN_WIDTH(IN_WIDTH), .ROWS(ROWS), .COLS(COLS)) u_bank1 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_cap & (r_wr_ptr == 1'b1)),
        .i_flat   (i_sum_flat),
        .i_set_no (i_sum_set_no),
        .i_row    (w_row_nxt),
        .i_col    (w_col_nxt),
        .o_elem   (w_elem[1]),
        .o_set_no (w_bank_set[1])
    );

    assign o_can_accept = ~(r_full[0] & r_full[1]);
    assign o_out_valid  = r_valid;
    assign o_out_data   = r_data;
    assign o_out_row    = r_row;
    assign o_out_col    = r_col;
    assign o_out_set_no = r_set_no;
    assign o_out_last   = r_last;
    assign o_overflow   = r_overflow;

endmodule
